text_row_sequencer: RTL and testbench
=====================================

// Module: text_row_sequencer
// PURPOSE
//  Sequences the 8x16 glyph ROM for one scanline of a text banner.
//  On start, it walks NUM_CHARS consecutive glyphs at one glyph row and fetches each row byte (1-cycle ROM latency).
//  It serialises the row bytes as a pixel stream with a valid/ready handshake, feeding the VGA pixel mux upstream of colour generation.
// PARAMETERS
//  NUM_CHARS  9  glyphs per banner line, legal 1..128
//  CHAR_BASE  0  glyph index of first character; CHAR_BASE+NUM_CHARS <= 128, else $error at elaboration
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   begin one line; sampled only in IDLE/DONE
//  row        in   4   glyph row (0..15), latched on accepted start
//  busy       out  1   high in FETCH/LOAD/SHIFT
//  done       out  1   one-cycle pulse, line complete
//  rom_addr   out  11  {glyph[6:0], row[3:0]} to glyph ROM
//  rom_data   in   8   ROM row byte, valid the cycle after rom_addr is presented
//  pix_valid  out  1   pix_data valid
//  pix_ready  in   1   downstream accepts the pixel when pix_valid & pix_ready
//  pix_data   out  1   current pixel, 1 = foreground
//  pix_last   out  1   high with the final pixel of the line
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, pix_valid, pix_data, pix_last = 0; rom_addr = 0; char_idx, bit_cnt, shreg, row_q = 0.
//  rom_addr = {CHAR_BASE + char_idx, row_q}, driven from registers, stable from FETCH through LOAD.
//  FSM states:
//   IDLE:  start -> row_q<=row, char_idx<=0, go FETCH.
//   FETCH: present rom_addr (ROM registers it this edge); 1 cycle -> LOAD.
//   LOAD:  shreg<=rom_data, bit_cnt<=0 -> SHIFT.
//   SHIFT: pix_valid=1, pix_data=shreg[7] (MSB = leftmost pixel).
//     On handshake: shift left, bit_cnt++.
//     After the last bit of a char: if char_idx==NUM_CHARS-1 -> DONE, else char_idx++ and -> FETCH.
//   DONE:  done=1 for 1 cycle, busy=0.
//     start here is accepted exactly as in IDLE (back-to-back lines); otherwise -> IDLE.
//  Start-to-first-pixel latency: 3 cycles (start edge, FETCH, LOAD), then pix_valid.
//  Inter-character gap: 2 cycles with pix_valid=0.
//  pix_valid & !pix_ready: pix_data, pix_last, shreg, bit_cnt all held; no drop, no duplicate.
//  pix_last = pix_valid & (char_idx==NUM_CHARS-1) & (bit_cnt==last bit); cleared with the handshake.
//  start while busy: ignored, row not relatched.
//  row changes after start: no effect until the next accepted start.
//  rst_n low mid-line, any state: immediate return to reset values; partial line discarded.
//  char_idx is 7 bits; CHAR_BASE+char_idx never wraps, guaranteed by the elaboration check.
// CONFIGURATION
//  Macro TEXT_SEQ_DOUBLE_WIDTH_EN:
//   defined: each ROM bit is emitted on 2 consecutive handshakes (16 pixels/char); bit_cnt widens to 4 bits;
//     shreg shifts every 2nd handshake; pix_last on the 16th pixel of the last char.
//   undefined: 8 pixels/char, 3-bit bit_cnt, shift every handshake.
// TESTING (bench uses the glyph ROM model: G,A,M,E,O,V,E,R,_ at glyphs 0..8)
//  1. NUM_CHARS=9, row=2, pix_ready=1
//     -> rom_addr 0x002,0x012,...,0x082 in order; first 8 pixels 0,1,1,1,1,1,0,0 (0x7C);
//        72 handshakes; pix_last only on the 72nd; one done pulse.
//  2. Same as 1 with pix_ready randomly toggling
//     -> identical 72-pixel stream; pix_data/pix_last stable while pix_valid & !pix_ready.
//  3. row=0, then row=15 -> 72 pixels, all 0; done each time.
//  4. start pulsed during SHIFT -> ignored.
//     rst_n low in SHIFT of char 4 -> all outputs 0 same cycle;
//     next start with row=3 -> restarts at rom_addr 0x003.
//  5. start held high in DONE -> second line starts with no IDLE cycle; 144 total handshakes, 2 done pulses.
//  6. TEXT_SEQ_DOUBLE_WIDTH_EN, NUM_CHARS=1, row=3
//     -> 16 pixels 1×14 then 0,0 (0xFE); pix_last on the 16th; done.

Source files
------------

// File: rtl/text_row_sequencer.sv
// -----------------------------------------------------------------------------
// text_row_sequencer
//
// Walks NUM_CHARS consecutive glyphs of an 8x16 glyph ROM at one glyph row.
// For each glyph it fetches the row byte and then sends the byte out MSB first
// as a pixel stream with a valid/ready handshake. The stream feeds the VGA
// pixel mux.
//
// Parameters:
//   NUM_CHARS  glyphs per banner line (1..128)
//   CHAR_BASE  glyph index of the first character (CHAR_BASE+NUM_CHARS <= 128)
//
// Optional feature (compile-time macro TEXT_SEQ_DOUBLE_WIDTH_EN):
//   defined   - each ROM bit is sent on 2 consecutive handshakes (16 px/char)
//   undefined - each ROM bit is sent once (8 px/char)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin one line (sampled in IDLE/DONE only)
//   row        in   glyph row 0..15, latched on an accepted start
//   busy       out  line in progress (FETCH/LOAD/SHIFT)
//   done       out  one-cycle pulse when the line completes
//   rom_addr   out  {glyph[6:0], row[3:0]} to the glyph ROM
//   rom_data   in   ROM row byte, valid the cycle after rom_addr
//   pix_valid  out  pix_data is valid
//   pix_ready  in   downstream accepts the pixel when pix_valid & pix_ready
//   pix_data   out  current pixel, 1 = foreground
//   pix_last   out  final pixel of the line
// -----------------------------------------------------------------------------
module text_row_sequencer #(
  parameter int NUM_CHARS = 9,
  parameter int CHAR_BASE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  row,
  output logic        busy,
  output logic        done,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic        pix_last
);

  // A bad glyph range would silently wrap the 7-bit glyph index, so it is
  // rejected when the design is elaborated.
  if (NUM_CHARS < 1 || NUM_CHARS > 128 || CHAR_BASE < 0 ||
      CHAR_BASE + NUM_CHARS > 128) begin : g_bad_cfg
    $error("text_row_sequencer: illegal NUM_CHARS/CHAR_BASE combination");
  end

`ifdef TEXT_SEQ_DOUBLE_WIDTH_EN
  localparam int BIT_CNT_W = 4;
`else
  localparam int BIT_CNT_W = 3;
`endif

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = '1;
  localparam logic [6:0]           LAST_CHAR = 7'(NUM_CHARS - 1);
  localparam logic [6:0]           BASE_IDX  = 7'(CHAR_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [6:0]            char_idx;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [7:0]            shreg;
  logic [3:0]            row_q;

  logic start_ok;   // start accepted this cycle
  logic handshake;  // pixel transferred this cycle
  logic shift_en;   // move to the next ROM bit on this handshake
  logic last_bit;   // current pixel is the final one of its character

  assign handshake = pix_valid & pix_ready;
  assign last_bit  = (bit_cnt == LAST_BIT);

`ifdef TEXT_SEQ_DOUBLE_WIDTH_EN
  // Every ROM bit is shown twice, so the register shifts on odd counts only.
  assign shift_en = bit_cnt[0];
`else
  assign shift_en = 1'b1;
`endif

  // NOTE: State registers use non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever the order of the
  // statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: Every output of this block gets a default before the case. This
  // way no path leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    pix_valid = 1'b0;
    start_ok  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        if (pix_ready && last_bit) begin
          state_d = (char_idx == LAST_CHAR) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A start in DONE runs the next line back to back, with no IDLE cycle.
        if (start) begin
          start_ok = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pix_data = pix_valid & shreg[7];
    pix_last = pix_valid & (char_idx == LAST_CHAR) & last_bit;
  end

  // Datapath. rom_addr is a register of its own. It reads 0 out of reset for
  // any CHAR_BASE, and it stays stable from FETCH through LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_idx <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      row_q    <= '0;
      rom_addr <= '0;
    end else begin
      if (start_ok) begin
        row_q    <= row;
        char_idx <= '0;
        rom_addr <= {BASE_IDX, row};
      end

      if (state_q == S_LOAD) begin
        shreg   <= rom_data;
        bit_cnt <= '0;
      end

      // While the pixel is stalled (valid without ready), everything holds.
      if (handshake) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (shift_en) begin
          shreg <= {shreg[6:0], 1'b0};
        end
        if (last_bit && char_idx != LAST_CHAR) begin
          char_idx <= char_idx + 7'd1;
          rom_addr <= {7'(BASE_IDX + char_idx + 7'd1), row_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_text_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_text_row_sequencer
//
// Testbench for text_row_sequencer with NUM_CHARS=9 and CHAR_BASE=0. It uses
// a glyph ROM model with the glyphs G,A,M,E,O,V,E,R,_ at indices 0..8.
//
// A reference model checks the outputs every cycle. The model keeps a queue
// of the pixels each line should produce (computed from the font table), the
// number of gap cycles before each character, and whether a line is in
// progress. Fixed literal values pin the model: 0x7C for G row 2, 0xFE for
// G row 3, restart address 0x003, and the handshake and done counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_text_row_sequencer;

  localparam int NUM_CHARS = 9;
  localparam int CHAR_BASE = 0;
`ifdef TEXT_SEQ_DOUBLE_WIDTH_EN
  localparam int PIXW = 2;
`else
  localparam int PIXW = 1;
`endif
  localparam int PPC      = 8 * PIXW;
  localparam int LINE_PIX = NUM_CHARS * PPC;
  localparam int BUDGET   = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  row;
  logic        busy;
  logic        done;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic        pix_last;

  text_row_sequencer #(.NUM_CHARS(NUM_CHARS), .CHAR_BASE(CHAR_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  // Glyph rows 2..13. Rows 0, 1, 14 and 15 are blank.
  logic [7:0] glyph_rows [0:8][0:11] = '{
    '{8'h7C,8'hFE,8'hC6,8'hC0,8'hC0,8'hDE,8'hC6,8'hC6,8'hFE,8'h7C,8'h00,8'h00}, // G
    '{8'h38,8'h6C,8'hC6,8'hC6,8'hFE,8'hFE,8'hC6,8'hC6,8'hC6,8'hC6,8'h00,8'h00}, // A
    '{8'hC6,8'hEE,8'hFE,8'hD6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h00,8'h00}, // M
    '{8'hFE,8'hFE,8'hC0,8'hC0,8'hFC,8'hFC,8'hC0,8'hC0,8'hFE,8'hFE,8'h00,8'h00}, // E
    '{8'h7C,8'hFE,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hFE,8'h7C,8'h00,8'h00}, // O
    '{8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h6C,8'h6C,8'h38,8'h10,8'h00,8'h00}, // V
    '{8'hFE,8'hFE,8'hC0,8'hC0,8'hFC,8'hFC,8'hC0,8'hC0,8'hFE,8'hFE,8'h00,8'h00}, // E
    '{8'hFC,8'hFE,8'hC6,8'hC6,8'hFC,8'hF8,8'hDC,8'hCE,8'hC6,8'hC6,8'h00,8'h00}, // R
    '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFF,8'h00}  // _
  };

  function automatic logic [7:0] font(input int g, input int r);
    if (g > 8 || r < 2 || r > 13) return 8'h00;
    return glyph_rows[g][r-2];
  endfunction

  // Glyph ROM with a 1-cycle read latency.
  always @(posedge clk) rom_data <= font(int'(rom_addr[10:4]), int'(rom_addr[3:0]));

  // ---------------------------------------------------------------------------
  // Result bookkeeping
  // ---------------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct packed { logic d; logic l; } pix_t;

  pix_t        exp_q[$];
  bit          m_in_line;
  bit          m_done_due;
  int          m_gap;
  int          m_char;
  int          m_pix;
  logic [3:0]  m_row;
  bit          acc;
  bit          exp_valid;

  // Logs used by the literal checks.
  int          hs_count;
  int          last_count;
  int          last_idx;
  int          done_count;
  logic        got_bits[$];
  logic [10:0] fetch_log[$];

  task automatic build_line(input logic [3:0] r);
    logic [7:0] b;
    exp_q.delete();
    for (int c = 0; c < NUM_CHARS; c++) begin
      b = font(CHAR_BASE + c, int'(r));
      for (int i = 7; i >= 0; i--)
        for (int k = 0; k < PIXW; k++)
          exp_q.push_back('{d: b[i], l: (c == NUM_CHARS-1 && i == 0 && k == PIXW-1)});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_last", pix_last, 0);
      check("rst_rom_addr", rom_addr, 0);
      m_in_line  = 0;
      m_done_due = 0;
      m_gap      = 0;
      exp_q.delete();
    end else begin
      check("busy", busy, m_in_line);
      check("done", done, m_done_due);
      exp_valid = m_in_line && (m_gap == 0);
      check("pix_valid", pix_valid, exp_valid);
      if (m_in_line && m_gap > 0) begin
        check("rom_addr", rom_addr, {7'(CHAR_BASE + m_char), m_row});
        if (m_gap == 2) fetch_log.push_back(rom_addr);
      end
      if (done) done_count++;

      acc        = start && !m_in_line;
      m_done_due = 0;
      if (m_in_line && m_gap > 0) begin
        m_gap--;
      end else if (exp_valid && exp_q.size() > 0) begin
        check("pix_data", pix_data, exp_q[0].d);
        check("pix_last", pix_last, exp_q[0].l);
        if (pix_ready) begin
          void'(exp_q.pop_front());
          got_bits.push_back(pix_data);
          hs_count++;
          if (pix_last) begin
            last_count++;
            last_idx = hs_count;
          end
          m_pix++;
          if (m_pix == PPC) begin
            m_pix = 0;
            m_char++;
            if (m_char == NUM_CHARS) begin
              m_in_line  = 0;
              m_done_due = 1;
            end else begin
              m_gap = 2;
            end
          end
        end
      end

      if (acc) begin
        m_in_line = 1;
        m_row     = row;
        m_char    = 0;
        m_pix     = 0;
        m_gap     = 2;
        build_line(row);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit rand_ready = 0;

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clear_logs();
    hs_count   = 0;
    last_count = 0;
    last_idx   = 0;
    done_count = 0;
    got_bits.delete();
    fetch_log.delete();
  endtask

  task automatic start_line(input logic [3:0] r);
    @(posedge clk);
    #1;
    start = 1'b1;
    row   = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    row   = 4'($urandom);  // must have no effect on the running line
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_count < target && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    check(name, done_count >= target, 1);
  endtask

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    while (hs_count < target && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    check(name, hs_count >= target, 1);
  endtask

  // Rebuilds the first ROM byte of the line from the pixels received.
  // In double-width mode it also counts the pixel pairs that differ.
  task automatic first_byte(output logic [7:0] b, output int pair_err);
    b        = 8'h00;
    pair_err = 0;
    for (int i = 0; i < 8; i++) begin
      if (i * PIXW < got_bits.size()) b[7-i] = got_bits[i*PIXW];
      for (int k = 1; k < PIXW; k++)
        if (i * PIXW + k >= got_bits.size() || got_bits[i*PIXW+k] !== got_bits[i*PIXW])
          pair_err++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic ref_bits[$];

  initial begin
    logic [7:0] b;
    int         perr;
    int         mm;
    int         ones;

    rst_n = 1'b0;
    start = 1'b0;
    row   = 4'd0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_rom_addr", rom_addr, 11'h000);
    rst_n = 1'b1;

    // 1: row 2, always ready
    clear_logs();
    start_line(4'd2);
    wait_done(1, "t1_done_timeout");
    check("t1_handshakes", hs_count, LINE_PIX);
    check("t1_last_count", last_count, 1);
    check("t1_last_index", last_idx, LINE_PIX);
    check("t1_done_pulses", done_count, 1);
    check("t1_fetch_count", fetch_log.size(), NUM_CHARS);
    for (int i = 0; i < NUM_CHARS && i < fetch_log.size(); i++)
      check($sformatf("t1_fetch_addr_%0d", i), fetch_log[i], 11'h002 + 11'(16 * i));
    first_byte(b, perr);
    check("t1_first_byte", b, 8'h7C);
    check("t1_pixel_pairs", perr, 0);
    ref_bits = got_bits;

    // 2: row 2, random back-pressure
    clear_logs();
    rand_ready = 1;
    start_line(4'd2);
    wait_done(1, "t2_done_timeout");
    rand_ready = 0;
    mm = (got_bits.size() != ref_bits.size()) ? 1 : 0;
    for (int i = 0; i < got_bits.size() && i < ref_bits.size(); i++)
      if (got_bits[i] !== ref_bits[i]) mm++;
    check("t2_handshakes", hs_count, LINE_PIX);
    check("t2_stream_diffs", mm, 0);
    check("t2_last_index", last_idx, LINE_PIX);

    // 3: blank rows 0 and 15
    for (int pass = 0; pass < 2; pass++) begin
      clear_logs();
      start_line(pass == 0 ? 4'd0 : 4'd15);
      wait_done(1, "t3_done_timeout");
      ones = 0;
      foreach (got_bits[i]) if (got_bits[i] === 1'b1) ones++;
      check($sformatf("t3_ones_pass%0d", pass), ones, 0);
      check($sformatf("t3_handshakes_pass%0d", pass), hs_count, LINE_PIX);
      check($sformatf("t3_done_pass%0d", pass), done_count, 1);
    end

    // 4: start during SHIFT is ignored; reset in the middle of char 4
    clear_logs();
    start_line(4'd5);
    wait_hs(4 * PPC + 3, "t4_reach_char4");
    @(posedge clk);
    #1;
    start = 1'b1;
    row   = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_hs(4 * PPC + 5, "t4_still_char4");
    @(posedge clk);
    #1;
    check("t4_busy_before_reset", busy, 1);
    check("t4_addr_before_reset", rom_addr, 11'h045);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_busy", busy, 0);
    check("t4_async_pix_valid", pix_valid, 0);
    check("t4_async_pix_data", pix_data, 0);
    check("t4_async_pix_last", pix_last, 0);
    check("t4_async_rom_addr", rom_addr, 0);
    check("t4_no_done", done_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    start_line(4'd3);
    wait_done(1, "t4_restart_timeout");
    check("t4_restart_fetch_count", fetch_log.size(), NUM_CHARS);
    if (fetch_log.size() > 0) check("t4_restart_addr", fetch_log[0], 11'h003);
    first_byte(b, perr);
    check("t4_row3_first_byte", b, 8'hFE);
    check("t4_row3_pixel_pairs", perr, 0);
    check("t4_handshakes", hs_count, LINE_PIX);

    // 5: start held high across DONE gives a back-to-back second line
    clear_logs();
    @(posedge clk);
    #1;
    start = 1'b1;
    row   = 4'd7;
    begin
      int n = 0;
      while (done_count < 1 && n < BUDGET) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    start = 1'b0;
    wait_done(2, "t5_done_timeout");
    check("t5_handshakes", hs_count, 2 * LINE_PIX);
    check("t5_done_pulses", done_count, 2);
    check("t5_last_count", last_count, 2);
    check("t5_fetch_count", fetch_log.size(), 2 * NUM_CHARS);
    if (fetch_log.size() > NUM_CHARS)
      check("t5_second_line_addr", fetch_log[NUM_CHARS], 11'h007);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
